// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: control bits, beat layout,
// occupancy state encoding and the control-masking helper.
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int PIPE_REGW = 5;
    localparam int CTRL_W    = 4;

    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic regwrite;
        logic memread;
    } ctrl_t;

    // Field order here is the bit order used when a beat is flattened.
    typedef struct packed {
        logic [PIPE_XLEN-1:0] alu_result;
        logic [PIPE_XLEN-1:0] rs2_data;
        logic [PIPE_REGW-1:0] rd;
        ctrl_t                ctrl;
    } beat_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // Control bits are only meaningful while a beat is valid.
    function automatic ctrl_t ctrl_mask(input logic valid, input ctrl_t c);
        return valid ? c : '0;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready holding buffer with occupancy state machine.
// With EX_MEM_PIPE_SKID_EN defined it is a two-entry skid buffer with a
// registered in_ready; otherwise a single entry whose in_ready is
// combinational (out_ready || !out_valid).
//
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   ONE   | one beat held in main_q, presented on out_data
//   TWO   | main_q presented, skid_q holds the next beat, in_ready low
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    occ_state_t   state;
    logic [W-1:0] main_q;
    logic         valid_q;
    logic         rdy_q;
    logic         push;
    logic         pop;

`ifdef EX_MEM_PIPE_SKID_EN
    logic [W-1:0] skid_q;
    assign in_ready = rdy_q;
`else
    // rdy_q only keeps in_ready low through reset and the first edge after it.
    assign in_ready = rdy_q && (out_ready || !valid_q);
`endif

    assign push      = in_valid && in_ready;
    assign pop       = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = state;

    // Occupancy FSM with its storage and registered valid/ready outputs; clr beats any transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            main_q  <= '0;
`ifdef EX_MEM_PIPE_SKID_EN
            skid_q  <= '0;
`endif
        end else if (clr) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q  <= in_data;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
`ifdef EX_MEM_PIPE_SKID_EN
                    if (push && !pop) begin
                        skid_q <= in_data;
                        state  <= TWO;
                        rdy_q  <= 1'b0;
                    end else if (push) begin
                        main_q <= in_data;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
`else
                    if (push) begin
                        main_q <= in_data;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
`endif
                end
                TWO: begin
`ifdef EX_MEM_PIPE_SKID_EN
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end else begin
                        rdy_q <= 1'b0;
                    end
`else
                    valid_q <= 1'b0;
                    state   <= EMPTY;
`endif
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: flattens the EX beat into pipe_skid_buf, gates
// the input with flush, masks control bits while empty and provides the
// forwarding tap. Optional two-entry skid: define EX_MEM_PIPE_SKID_EN.
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN,
    parameter int REGW = PIPE_REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [REGW-1:0] in_rd,
    input  logic [3:0]      in_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [REGW-1:0] out_rd,
    output logic [3:0]      out_ctrl,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [1:0]      occupancy
);

    localparam int PW = 2 * XLEN + REGW + CTRL_W;

    logic [PW-1:0] in_beat;
    logic [PW-1:0] out_beat;
    ctrl_t         held_ctrl;

    // Same field order as beat_t.
    assign in_beat = {in_alu_result, in_rs2_data, in_rd, in_ctrl};

    pipe_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .in_valid  (in_valid && !flush),
        .in_data   (in_beat),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_beat),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    assign out_alu_result = out_beat[PW-1 -: XLEN];
    assign out_rs2_data   = out_beat[CTRL_W+REGW +: XLEN];
    assign out_rd         = out_beat[CTRL_W +: REGW];
    assign held_ctrl      = ctrl_t'(out_beat[CTRL_W-1:0]);

    assign out_ctrl  = ctrl_mask(out_valid, held_ctrl);
    assign fwd_valid = out_valid && held_ctrl.regwrite && (out_rd != '0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_result;

endmodule
